interrupt_controller: RTL and testbench

Interrupt source side of the CPU's interrupt handshake: it drives `interrupt_r` and `NON_maskable_interrupt` into the multi-cycle MIPS core. It collects `N_IRQ` device request lines plus one NMI line, applies a mask, and selects the highest-priority source. It raises the request with a stable vector, waits for the CPU's acknowledge and end-of-interrupt, and allows one level of NMI preemption over a maskable handler in service. It sits between the peripherals and `Top`'s interrupt inputs.

---
 rtl/intc_pkg.sv | 24 ++
 rtl/intc_prio_enc.sv | 27 ++
 rtl/interrupt_controller.sv | 217 +++++++++++++++++++++
 tb/tb_interrupt_controller.sv | 259 +++++++++++++++++++++++++
 4 files changed

// File: rtl/intc_pkg.sv
// -----------------------------------------------------------------------------
// intc_pkg
// Shared definitions for the interrupt controller slice:
//   - default number of maskable request lines and matching vector width
//   - vector value reported while an NMI is requested or in service
//   - controller FSM state encoding
// -----------------------------------------------------------------------------
package intc_pkg;

    localparam int N_IRQ_DEF = 32'd8;
    localparam int VEC_W_DEF = 32'd3;

    // int_vector reads as this value during NMI_REQ / NMI_SERV
    localparam int unsigned NMI_VEC = 32'd0;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_REQ      = 3'd1,
        ST_SERV     = 3'd2,
        ST_NMI_REQ  = 3'd3,
        ST_NMI_SERV = 3'd4
    } intc_state_e;

endpackage

// File: rtl/intc_prio_enc.sv
// -----------------------------------------------------------------------------
// intc_prio_enc
// Combinational priority encoder, lowest set index wins.
// Ports:
//   elig  in  N   eligible request vector (pending and unmasked)
//   any   out 1   at least one bit of elig is set
//   idx   out W   index of the lowest set bit (0 when none set)
// -----------------------------------------------------------------------------
module intc_prio_enc #(
    parameter int N = 32'd8,
    parameter int W = 32'd3
) (
    input  logic [N-1:0] elig,
    output logic         any,
    output logic [W-1:0] idx
);

    // Scan from the top down so the lowest set index is the last one written
    always_comb begin
        any = |elig;
        idx = {W{1'b0}};
        for (int i = N - 1; i >= 0; i--) begin
            idx = elig[i] ? W'(i) : idx;
        end
    end

endmodule

// File: rtl/interrupt_controller.sv
// -----------------------------------------------------------------------------
// interrupt_controller
// Collects N_IRQ maskable device requests plus one NMI, applies a mask,
// selects the highest-priority (lowest index) source and runs the request /
// acknowledge / end-of-interrupt handshake with the CPU. An NMI may preempt
// a maskable request or a maskable handler in service (one level deep).
//
// Build option: define IRQ_EDGE_TRIGGER_EN for rising-edge capture of irq_in
// (pend bit cleared by the ack of that vector). Without it, pend is irq_in
// registered for one cycle (level mode).
//
// Ports:
//   clock                   in   system clock, rising edge
//   reset                   in   synchronous active-high reset
//   irq_in[N_IRQ]           in   device request lines
//   nmi_in                  in   non-maskable request, rising-edge triggered
//   mask_wr / mask_data     in   mask register load strobe / value (1 = off)
//   CPU_busy                in   blocks starting a new maskable request
//   int_ack                 in   CPU accepts the current request
//   eoi                     in   end of the handler in service
//   interrupt_r             out  maskable request to the CPU
//   NON_maskable_interrupt  out  NMI request to the CPU
//   int_vector[VEC_W]       out  requested / in-service source (0 for NMI)
//   in_service              out  a handler is active
// -----------------------------------------------------------------------------
module interrupt_controller
    import intc_pkg::*;
#(
    parameter int N_IRQ = N_IRQ_DEF,
    parameter int VEC_W = VEC_W_DEF
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [N_IRQ-1:0] irq_in,
    input  logic             nmi_in,
    input  logic             mask_wr,
    input  logic [N_IRQ-1:0] mask_data,
    input  logic             CPU_busy,
    input  logic             int_ack,
    input  logic             eoi,
    output logic             interrupt_r,
    output logic             NON_maskable_interrupt,
    output logic [VEC_W-1:0] int_vector,
    output logic             in_service
);

    intc_state_e      state_r, state_s;
    logic [N_IRQ-1:0] pend_r, pend_s, mask_r, elig_s;
    logic             nmi_prev_r, nmi_pend_r, nmi_pend_s;
    logic [VEC_W-1:0] cur_vec_r, cur_vec_s, win_s, vec_s;
    logic             resume_r, resume_s, req_held_r, req_held_s;
    logic             any_s, ack_nmi_s;
    logic             irq_out_s, nmi_out_s, ins_out_s;

    assign elig_s = pend_r & ~mask_r;

    intc_prio_enc #(
        .N (N_IRQ),
        .W (VEC_W)
    ) u_prio_enc (
        .elig (elig_s),
        .any  (any_s),
        .idx  (win_s)
    );

`ifdef IRQ_EDGE_TRIGGER_EN
    logic [N_IRQ-1:0] irq_prev_r, pend_set_s, pend_clr_s;
    logic             ack_irq_s;

    // Edge capture: a new rising edge beats a same-cycle ack clear
    always_comb begin
        ack_irq_s  = (state_r == ST_REQ) && int_ack;
        pend_set_s = irq_in & ~irq_prev_r;
        pend_clr_s = ack_irq_s ? ({{(N_IRQ-1){1'b0}}, 1'b1} << cur_vec_r)
                               : {N_IRQ{1'b0}};
        pend_s     = (pend_r & ~pend_clr_s) | pend_set_s;
    end

    // Edge-detect history for the request lines
    always_ff @(posedge clock) begin
        if (reset) begin
            irq_prev_r <= {N_IRQ{1'b0}};
        end else begin
            irq_prev_r <= irq_in;
        end
    end
`else
    // Level mode: pend simply follows the lines one cycle late
    always_comb begin
        pend_s = irq_in;
    end
`endif

    // NMI pending: a fresh rising edge beats a same-cycle ack clear
    always_comb begin
        nmi_pend_s = (nmi_pend_r & ~ack_nmi_s) | (nmi_in & ~nmi_prev_r);
    end

    // Controller FSM next state; cur_vec is never overwritten while an NMI is
    // handled, so it doubles as the saved vector of the one-level stack
    always_comb begin
        state_s    = state_r;
        cur_vec_s  = cur_vec_r;
        resume_s   = resume_r;
        req_held_s = req_held_r;
        ack_nmi_s  = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (nmi_pend_r) begin
                    state_s    = ST_NMI_REQ;
                    resume_s   = 1'b0;
                    req_held_s = 1'b0;
                end else if (any_s && !CPU_busy) begin
                    state_s   = ST_REQ;
                    cur_vec_s = win_s;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_REQ: begin
                if (int_ack) begin
                    state_s = ST_SERV;
                end else if (nmi_pend_r) begin
                    state_s    = ST_NMI_REQ;
                    req_held_s = 1'b1;
                    resume_s   = 1'b0;
                end else begin
                    state_s = ST_REQ;
                end
            end
            ST_SERV: begin
                // An eoi in the same cycle ends the handler, so nothing resumes
                if (nmi_pend_r) begin
                    state_s    = ST_NMI_REQ;
                    resume_s   = !eoi;
                    req_held_s = 1'b0;
                end else if (eoi) begin
                    state_s = ST_IDLE;
                end else begin
                    state_s = ST_SERV;
                end
            end
            ST_NMI_REQ: begin
                if (int_ack) begin
                    state_s   = ST_NMI_SERV;
                    ack_nmi_s = 1'b1;
                end else begin
                    state_s = ST_NMI_REQ;
                end
            end
            ST_NMI_SERV: begin
                if (eoi) begin
                    if (resume_r) begin
                        state_s = ST_SERV;
                    end else if (req_held_r) begin
                        state_s = ST_REQ;
                    end else begin
                        state_s = ST_IDLE;
                    end
                    resume_s   = 1'b0;
                    req_held_s = 1'b0;
                end else begin
                    state_s = ST_NMI_SERV;
                end
            end
            default: begin
                state_s    = ST_IDLE;
                resume_s   = 1'b0;
                req_held_s = 1'b0;
            end
        endcase
    end

    // Outputs are decoded from the next state so they can be registered
    always_comb begin
        irq_out_s = (state_s == ST_REQ);
        nmi_out_s = (state_s == ST_NMI_REQ);
        ins_out_s = (state_s == ST_SERV) || (state_s == ST_NMI_SERV);
        if ((state_s == ST_REQ) || (state_s == ST_SERV)) begin
            vec_s = cur_vec_s;
        end else begin
            vec_s = VEC_W'(NMI_VEC);
        end
    end

    // State, pending, mask and registered outputs
    always_ff @(posedge clock) begin
        if (reset) begin
            state_r                <= ST_IDLE;
            pend_r                 <= {N_IRQ{1'b0}};
            mask_r                 <= {N_IRQ{1'b1}};
            nmi_prev_r             <= 1'b0;
            nmi_pend_r             <= 1'b0;
            cur_vec_r              <= {VEC_W{1'b0}};
            resume_r               <= 1'b0;
            req_held_r             <= 1'b0;
            interrupt_r            <= 1'b0;
            NON_maskable_interrupt <= 1'b0;
            int_vector             <= {VEC_W{1'b0}};
            in_service             <= 1'b0;
        end else begin
            state_r                <= state_s;
            pend_r                 <= pend_s;
            mask_r                 <= mask_wr ? mask_data : mask_r;
            nmi_prev_r             <= nmi_in;
            nmi_pend_r             <= nmi_pend_s;
            cur_vec_r              <= cur_vec_s;
            resume_r               <= resume_s;
            req_held_r             <= req_held_s;
            interrupt_r            <= irq_out_s;
            NON_maskable_interrupt <= nmi_out_s;
            int_vector             <= vec_s;
            in_service             <= ins_out_s;
        end
    end

endmodule

// File: tb/tb_interrupt_controller.sv
// -----------------------------------------------------------------------------
// tb_interrupt_controller
// Table-driven bench for interrupt_controller (default parameters). Each
// table row holds the inputs driven before one rising edge and the outputs
// expected just after it. A randomized priority/mask sweep follows.
// -----------------------------------------------------------------------------
module tb_interrupt_controller;

    logic       clock = 1'b0;
    logic       reset;
    logic [7:0] irq_in;
    logic       nmi_in;
    logic       mask_wr;
    logic [7:0] mask_data;
    logic       CPU_busy;
    logic       int_ack;
    logic       eoi;
    logic       interrupt_r;
    logic       NON_maskable_interrupt;
    logic [2:0] int_vector;
    logic       in_service;

    always #5 clock = ~clock;

    interrupt_controller dut (
        .clock                  (clock),
        .reset                  (reset),
        .irq_in                 (irq_in),
        .nmi_in                 (nmi_in),
        .mask_wr                (mask_wr),
        .mask_data              (mask_data),
        .CPU_busy               (CPU_busy),
        .int_ack                (int_ack),
        .eoi                    (eoi),
        .interrupt_r            (interrupt_r),
        .NON_maskable_interrupt (NON_maskable_interrupt),
        .int_vector             (int_vector),
        .in_service             (in_service)
    );

    typedef struct {
        logic       rst;
        logic [7:0] irq;
        logic       nmi;
        logic       mwr;
        logic [7:0] mdata;
        logic       busy;
        logic       ack;
        logic       eoi;
        logic       e_ir;
        logic       e_nm;
        logic [2:0] e_vec;
        logic       e_ins;
    } vec_t;

    typedef struct {
        int         id;
        logic       e_ir;
        logic       e_nm;
        logic [2:0] e_vec;
        logic       e_ins;
    } exp_t;

    vec_t tbl[$];
    exp_t sb[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    task automatic add(input logic rst, input logic [7:0] irq, input logic nmi,
                       input logic mwr, input logic [7:0] md, input logic busy,
                       input logic ack, input logic e, input logic ir,
                       input logic nm, input logic [2:0] v, input logic ins);
        vec_t r;
        r = '{rst, irq, nmi, mwr, md, busy, ack, e, ir, nm, v, ins};
        tbl.push_back(r);
    endtask

    task automatic chk(input string name, input int id, input logic [31:0] act,
                       input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s #%0d: got %0h, expected %0h", name, id, act, req);
        end
    endtask

    task automatic idle_inputs();
        reset = 1'b0; irq_in = 8'h00; nmi_in = 1'b0; mask_wr = 1'b0;
        mask_data = 8'h00; CPU_busy = 1'b0; int_ack = 1'b0; eoi = 1'b0;
    endtask

    exp_t       e;
    logic [7:0] pat, msk, el;
    int         exp_i;
    logic       got;

    initial begin
        idle_inputs();
        reset = 1'b1;

        //   rst irq    nmi mwr mdata  bsy ack eoi | ir nm vec ins
        // reset and basic request on vector 5
        add(1, 8'h00, 0, 0, 8'h00, 0, 0, 0, 0, 0, 3'd0, 0);
        add(1, 8'h00, 0, 0, 8'h00, 0, 0, 0, 0, 0, 3'd0, 0);
        add(0, 8'h00, 0, 0, 8'h00, 0, 0, 0, 0, 0, 3'd0, 0);
        add(0, 8'h00, 0, 1, 8'h00, 0, 0, 0, 0, 0, 3'd0, 0);
        add(0, 8'h20, 0, 0, 8'h00, 0, 0, 0, 0, 0, 3'd0, 0);
        add(0, 8'h00, 0, 0, 8'h00, 0, 0, 0, 1, 0, 3'd5, 0);
        add(0, 8'h00, 0, 0, 8'h00, 0, 0, 0, 1, 0, 3'd5, 0);
        add(0, 8'h00, 0, 0, 8'h00, 0, 1, 0, 0, 0, 3'd5, 1);
        add(0, 8'h00, 0, 0, 8'h00, 0, 0, 0, 0, 0, 3'd5, 1);
        add(0, 8'h00, 0, 0, 8'h00, 0, 0, 1, 0, 0, 3'd0, 0);
        add(0, 8'h00, 0, 0, 8'h00, 0, 0, 0, 0, 0, 3'd0, 0);
        // lines 2 and 6 together: 2 first, then 6
        add(0, 8'h44, 0, 0, 8'h00, 0, 0, 0, 0, 0, 3'd0, 0);
        add(0, 8'h44, 0, 0, 8'h00, 0, 0, 0, 1, 0, 3'd2, 0);
        add(0, 8'h44, 0, 0, 8'h00, 0, 1, 0, 0, 0, 3'd2, 1);
        add(0, 8'h40, 0, 0, 8'h00, 0, 0, 0, 0, 0, 3'd2, 1);
        add(0, 8'h40, 0, 0, 8'h00, 0, 0, 1, 0, 0, 3'd0, 0);
        add(0, 8'h40, 0, 0, 8'h00, 0, 0, 0, 1, 0, 3'd6, 0);
        add(0, 8'h40, 0, 0, 8'h00, 0, 1, 0, 0, 0, 3'd6, 1);
        add(0, 8'h00, 0, 0, 8'h00, 0, 0, 0, 0, 0, 3'd6, 1);
        add(0, 8'h00, 0, 0, 8'h00, 0, 0, 1, 0, 0, 3'd0, 0);
        add(0, 8'h00, 0, 0, 8'h00, 0, 0, 0, 0, 0, 3'd0, 0);
        // masked source held pending, released by mask write
        add(0, 8'h00, 0, 1, 8'h04, 0, 0, 0, 0, 0, 3'd0, 0);
        add(0, 8'h04, 0, 0, 8'h00, 0, 0, 0, 0, 0, 3'd0, 0);
        add(0, 8'h04, 0, 0, 8'h00, 0, 0, 0, 0, 0, 3'd0, 0);
        add(0, 8'h04, 0, 0, 8'h00, 0, 0, 0, 0, 0, 3'd0, 0);
        add(0, 8'h04, 0, 1, 8'h00, 0, 0, 0, 0, 0, 3'd0, 0);
        add(0, 8'h04, 0, 0, 8'h00, 0, 0, 0, 1, 0, 3'd2, 0);
        add(0, 8'h04, 0, 1, 8'hFF, 0, 0, 0, 1, 0, 3'd2, 0);
        add(0, 8'h04, 0, 0, 8'h00, 0, 1, 0, 0, 0, 3'd2, 1);
        add(0, 8'h00, 0, 0, 8'h00, 0, 0, 0, 0, 0, 3'd2, 1);
        add(0, 8'h00, 0, 0, 8'h00, 0, 0, 1, 0, 0, 3'd0, 0);
        add(0, 8'h00, 0, 1, 8'h00, 0, 0, 0, 0, 0, 3'd0, 0);
        // CPU_busy gates only the start of a request
        add(0, 8'h02, 0, 0, 8'h00, 1, 0, 0, 0, 0, 3'd0, 0);
        add(0, 8'h02, 0, 0, 8'h00, 1, 0, 0, 0, 0, 3'd0, 0);
        add(0, 8'h02, 0, 0, 8'h00, 1, 0, 0, 0, 0, 3'd0, 0);
        add(0, 8'h02, 0, 0, 8'h00, 0, 0, 0, 1, 0, 3'd1, 0);
        add(0, 8'h02, 0, 0, 8'h00, 1, 0, 0, 1, 0, 3'd1, 0);
        add(0, 8'h02, 0, 0, 8'h00, 0, 1, 0, 0, 0, 3'd1, 1);
        add(0, 8'h00, 0, 0, 8'h00, 0, 0, 0, 0, 0, 3'd1, 1);
        add(0, 8'h00, 0, 0, 8'h00, 0, 0, 1, 0, 0, 3'd0, 0);
        // NMI preempting SERV of vector 3, then resume
        add(0, 8'h08, 0, 0, 8'h00, 0, 0, 0, 0, 0, 3'd0, 0);
        add(0, 8'h00, 0, 0, 8'h00, 0, 0, 0, 1, 0, 3'd3, 0);
        add(0, 8'h00, 0, 0, 8'h00, 0, 1, 0, 0, 0, 3'd3, 1);
        add(0, 8'h00, 1, 0, 8'h00, 0, 0, 0, 0, 0, 3'd3, 1);
        add(0, 8'h00, 1, 0, 8'h00, 0, 0, 0, 0, 1, 3'd0, 0);
        add(0, 8'h00, 0, 0, 8'h00, 0, 0, 0, 0, 1, 3'd0, 0);
        add(0, 8'h00, 0, 0, 8'h00, 0, 1, 0, 0, 0, 3'd0, 1);
        add(0, 8'h00, 0, 0, 8'h00, 0, 0, 0, 0, 0, 3'd0, 1);
        add(0, 8'h00, 0, 0, 8'h00, 0, 0, 1, 0, 0, 3'd3, 1);
        add(0, 8'h00, 0, 0, 8'h00, 0, 0, 0, 0, 0, 3'd3, 1);
        add(0, 8'h00, 0, 0, 8'h00, 0, 0, 1, 0, 0, 3'd0, 0);
        // eoi ignored in REQ, ack ignored in SERV
        add(0, 8'h01, 0, 0, 8'h00, 0, 0, 0, 0, 0, 3'd0, 0);
        add(0, 8'h00, 0, 0, 8'h00, 0, 0, 0, 1, 0, 3'd0, 0);
        add(0, 8'h00, 0, 0, 8'h00, 0, 0, 1, 1, 0, 3'd0, 0);
        add(0, 8'h00, 0, 0, 8'h00, 0, 1, 0, 0, 0, 3'd0, 1);
        add(0, 8'h00, 0, 0, 8'h00, 0, 1, 0, 0, 0, 3'd0, 1);
        add(0, 8'h00, 0, 0, 8'h00, 0, 0, 1, 0, 0, 3'd0, 0);
        // NMI preempting REQ of vector 4, request re-raised afterwards
        add(0, 8'h10, 0, 0, 8'h00, 0, 0, 0, 0, 0, 3'd0, 0);
        add(0, 8'h00, 0, 0, 8'h00, 0, 0, 0, 1, 0, 3'd4, 0);
        add(0, 8'h00, 1, 0, 8'h00, 0, 0, 0, 1, 0, 3'd4, 0);
        add(0, 8'h00, 1, 0, 8'h00, 0, 0, 0, 0, 1, 3'd0, 0);
        add(0, 8'h00, 0, 0, 8'h00, 0, 1, 0, 0, 0, 3'd0, 1);
        add(0, 8'h00, 0, 0, 8'h00, 0, 0, 1, 1, 0, 3'd4, 0);
        add(0, 8'h00, 0, 0, 8'h00, 0, 1, 0, 0, 0, 3'd4, 1);
        add(0, 8'h00, 0, 0, 8'h00, 0, 0, 1, 0, 0, 3'd0, 0);
        // NMI from IDLE ignores CPU_busy
        add(0, 8'h00, 1, 0, 8'h00, 1, 0, 0, 0, 0, 3'd0, 0);
        add(0, 8'h00, 0, 0, 8'h00, 1, 0, 0, 0, 1, 3'd0, 0);
        add(0, 8'h00, 0, 0, 8'h00, 0, 1, 0, 0, 0, 3'd0, 1);
        add(0, 8'h00, 0, 0, 8'h00, 0, 0, 1, 0, 0, 3'd0, 0);
        // reset during REQ; held line waits for a mask write
        add(0, 8'h20, 0, 0, 8'h00, 0, 0, 0, 0, 0, 3'd0, 0);
        add(0, 8'h20, 0, 0, 8'h00, 0, 0, 0, 1, 0, 3'd5, 0);
        add(1, 8'h20, 0, 0, 8'h00, 0, 0, 0, 0, 0, 3'd0, 0);
        add(0, 8'h20, 0, 0, 8'h00, 0, 0, 0, 0, 0, 3'd0, 0);
        add(0, 8'h20, 0, 0, 8'h00, 0, 0, 0, 0, 0, 3'd0, 0);
        add(0, 8'h20, 0, 1, 8'h00, 0, 0, 0, 0, 0, 3'd0, 0);
        add(0, 8'h20, 0, 0, 8'h00, 0, 0, 0, 1, 0, 3'd5, 0);
        add(0, 8'h20, 0, 0, 8'h00, 0, 1, 0, 0, 0, 3'd5, 1);
        add(0, 8'h00, 0, 0, 8'h00, 0, 0, 0, 0, 0, 3'd5, 1);
        add(0, 8'h00, 0, 0, 8'h00, 0, 0, 1, 0, 0, 3'd0, 0);

        for (int i = 0; i < tbl.size(); i++) begin
            @(negedge clock);
            reset     = tbl[i].rst;
            irq_in    = tbl[i].irq;
            nmi_in    = tbl[i].nmi;
            mask_wr   = tbl[i].mwr;
            mask_data = tbl[i].mdata;
            CPU_busy  = tbl[i].busy;
            int_ack   = tbl[i].ack;
            eoi       = tbl[i].eoi;
            sb.push_back('{i, tbl[i].e_ir, tbl[i].e_nm, tbl[i].e_vec, tbl[i].e_ins});
            @(posedge clock);
            #1;
            e = sb.pop_front();
            chk("interrupt_r", e.id, 32'(interrupt_r), 32'(e.e_ir));
            chk("nmi_out", e.id, 32'(NON_maskable_interrupt), 32'(e.e_nm));
            chk("int_vector", e.id, 32'(int_vector), 32'(e.e_vec));
            chk("in_service", e.id, 32'(in_service), 32'(e.e_ins));
        end

        // Randomized priority / mask sweep; reset clears any leftover pend bits
        for (int k = 0; k < 12; k++) begin
            @(negedge clock);
            idle_inputs();
            pat = 8'($urandom_range(1, 255));
            msk = 8'($urandom_range(0, 255));
            if ((pat & ~msk) == 8'h00) msk = 8'h00;
            el = pat & ~msk;
            exp_i = 0;
            for (int b = 7; b >= 0; b--) begin
                if (el[b]) exp_i = b;
            end
            reset = 1'b1;
            @(negedge clock);
            reset     = 1'b0;
            mask_wr   = 1'b1;
            mask_data = msk;
            @(negedge clock);
            mask_wr = 1'b0;
            irq_in  = pat;
            sb.push_back('{1000 + k, 1'b1, 1'b0, 3'(exp_i), 1'b0});
            got = 1'b0;
            for (int c = 0; c < 8 && !got; c++) begin
                @(posedge clock);
                #1;
                if (interrupt_r) got = 1'b1;
            end
            e = sb.pop_front();
            chk("sweep_req", e.id, 32'(got), 32'(e.e_ir));
            chk("sweep_vec", e.id, 32'(int_vector), 32'(e.e_vec));
            @(negedge clock);
            int_ack = 1'b1;
            @(negedge clock);
            int_ack = 1'b0;
            irq_in  = 8'h00;
            chk("sweep_ins", e.id, 32'(in_service), 32'd1);
            chk("sweep_drop", e.id, 32'(interrupt_r), 32'd0);
            @(negedge clock);
            eoi = 1'b1;
            @(negedge clock);
            eoi = 1'b0;
            chk("sweep_eoi", e.id, 32'(in_service), 32'd0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
